retire_stage: RTL and testbench

- Consumer end of the ROB retire interface.
- Each cycle it reads up to N oldest ROB entries (rob_outputs / rob_outputs_valid) and decides how many retire, in order. It returns that count as num_retiring.
- Retiring entries release old physical registers to the free list and update the architectural map.
- It keeps a shadow head pointer and a per-ROB-slot completion bitmap fed by CDB broadcasts. A halt FSM stops retirement.

---
 rtl/retire_stage_if.sv | 52 +++++
 rtl/retire_stage.sv | 131 +++++++++++++
 tb/tb_retire_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_stage_if.sv
// ROB-to-retire bus: oldest-first ROB entries, CDB completion lanes, squash info,
// and the retirement results (free list, architectural map, counters).
interface retire_stage_if #(
   parameter int N      = 3,
   parameter int ROB_SZ = 8,
   parameter int CDB_W  = N,
   parameter int PREG_W = 6,
   parameter int REG_W  = 5
);
   localparam int NSB = $clog2(N + 1);
   localparam int RSB = $clog2(ROB_SZ);

   // Handshake: the ROB offers rob_outputs_valid entries every cycle; this block answers
   // num_retiring combinationally and both sides commit that count at the same clock edge.
   // There is no backpressure in either direction.
   logic [N-1:0][PREG_W-1:0]    rob_outputs_t;
   logic [N-1:0][PREG_W-1:0]    rob_outputs_t_old;
   logic [N-1:0][REG_W-1:0]     rob_outputs_dest_reg_idx;
   logic [N-1:0]                rob_outputs_has_dest;
   logic [N-1:0]                rob_outputs_halt;
   logic [NSB-1:0]              rob_outputs_valid;
   logic [RSB-1:0]              rob_tail;
   logic                        tail_restore_valid;
   logic [RSB-1:0]              tail_restore;
   logic [CDB_W-1:0]            cdb_valid;
   logic [CDB_W-1:0][RSB-1:0]   cdb_rob_idx;

   logic [NSB-1:0]              num_retiring;
   logic [N-1:0]                free_valid;
   logic [N-1:0][PREG_W-1:0]    free_preg;
   logic [N-1:0]                arch_map_valid;
   logic [N-1:0][REG_W-1:0]     arch_map_reg;
   logic [N-1:0][PREG_W-1:0]    arch_map_preg;
   logic                        halted;
   logic [31:0]                 retired_count;

   modport master (
      output rob_outputs_t, rob_outputs_t_old, rob_outputs_dest_reg_idx,
             rob_outputs_has_dest, rob_outputs_halt, rob_outputs_valid,
             rob_tail, tail_restore_valid, tail_restore, cdb_valid, cdb_rob_idx,
      input  num_retiring, free_valid, free_preg, arch_map_valid, arch_map_reg,
             arch_map_preg, halted, retired_count
   );

   modport slave (
      input  rob_outputs_t, rob_outputs_t_old, rob_outputs_dest_reg_idx,
             rob_outputs_has_dest, rob_outputs_halt, rob_outputs_valid,
             rob_tail, tail_restore_valid, tail_restore, cdb_valid, cdb_rob_idx,
      output num_retiring, free_valid, free_preg, arch_map_valid, arch_map_reg,
             arch_map_preg, halted, retired_count
   );
endinterface

// File: rtl/retire_stage.sv
// In-order retire stage: tracks completion per ROB slot and retires the complete prefix.
// Optional macro RETIRE_CDB_BYPASS_EN lets same-cycle CDB completions count toward retirement.
module retire_stage #(
   parameter int N      = 3,
   parameter int ROB_SZ = 8,
   parameter int CDB_W  = N,
   parameter int PREG_W = 6,
   parameter int REG_W  = 5
) (
   input logic           clock,
   input logic           reset,
   retire_stage_if.slave bus
);
   localparam int NSB = $clog2(N + 1);
   localparam int RSB = $clog2(ROB_SZ);

   typedef enum logic {RUN, HALTED} state_e;

   state_e            state_q, state_d;
   logic [RSB-1:0]    head_q, head_d;
   logic [ROB_SZ-1:0] complete_q, complete_d;
   logic [31:0]       count_q, count_d;

   logic [ROB_SZ-1:0] cdb_set, squash_clr, avail, retire_clr;
   logic [NSB-1:0]    nr;
   logic              halt_ret;
   logic              blocked;
   logic [RSB-1:0]    slot;
   logic [N-1:0]              free_valid;
   logic [N-1:0][PREG_W-1:0]  free_preg;
   logic [N-1:0]              map_valid;
   logic [N-1:0][REG_W-1:0]   map_reg;
   logic [N-1:0][PREG_W-1:0]  map_preg;

   function automatic logic [RSB-1:0] wrap_add(input logic [RSB-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= ROB_SZ) s = s - ROB_SZ;
      return RSB'(s);
   endfunction

   function automatic int sub_mod(input logic [RSB-1:0] a, input logic [RSB-1:0] b);
      int d;
      d = int'(a) - int'(b);
      if (d < 0) d = d + ROB_SZ;
      return d;
   endfunction

   // Completion sets from the CDB and the squash window [tail_restore, rob_tail).
   always_comb begin
      cdb_set    = '0;
      squash_clr = '0;
      for (int l = 0; l < CDB_W; l++) begin
         if (bus.cdb_valid[l]) cdb_set[bus.cdb_rob_idx[l]] = 1'b1;
      end
      if (bus.tail_restore_valid) begin
         for (int s = 0; s < ROB_SZ; s++) begin
            if (sub_mod(RSB'(s), bus.tail_restore) < sub_mod(bus.rob_tail, bus.tail_restore))
               squash_clr[s] = 1'b1;
         end
      end
`ifdef RETIRE_CDB_BYPASS_EN
      avail = complete_q | (cdb_set & ~squash_clr);
`else
      avail = complete_q;
`endif
   end

   // Retire the contiguous complete prefix; a halt entry retires but blocks younger lanes.
   always_comb begin
      nr         = '0;
      halt_ret   = 1'b0;
      retire_clr = '0;
      blocked    = reset || (state_q == HALTED);
      slot       = '0;
      free_valid = '0;
      free_preg  = '0;
      map_valid  = '0;
      map_reg    = '0;
      map_preg   = '0;
      for (int i = 0; i < N; i++) begin
         slot = wrap_add(head_q, i);
         if (!blocked && (i < int'(bus.rob_outputs_valid)) && avail[slot]) begin
            nr               = NSB'(i + 1);
            retire_clr[slot] = 1'b1;
            free_valid[i]    = bus.rob_outputs_has_dest[i];
            free_preg[i]     = bus.rob_outputs_t_old[i];
            map_valid[i]     = bus.rob_outputs_has_dest[i];
            map_reg[i]       = bus.rob_outputs_dest_reg_idx[i];
            map_preg[i]      = bus.rob_outputs_t[i];
            if (bus.rob_outputs_halt[i]) begin
               halt_ret = 1'b1;
               blocked  = 1'b1;
            end
         end else begin
            blocked = 1'b1;
         end
      end
   end

   always_comb begin
      complete_d = ((complete_q & ~retire_clr) | cdb_set) & ~squash_clr;
      head_d     = wrap_add(head_q, int'(nr));
      count_d    = count_q + 32'(nr);
      state_d    = state_q;
      if (state_q == RUN && halt_ret) state_d = HALTED;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= RUN;
         head_q     <= '0;
         complete_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         complete_q <= complete_d;
         count_q    <= count_d;
      end
   end

   assign bus.num_retiring   = nr;
   assign bus.free_valid     = free_valid;
   assign bus.free_preg      = free_preg;
   assign bus.arch_map_valid = map_valid;
   assign bus.arch_map_reg   = map_reg;
   assign bus.arch_map_preg  = map_preg;
   assign bus.halted         = (state_q == HALTED);
   assign bus.retired_count  = count_q;
endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage with N=3, ROB_SZ=8; expectations are hand-computed.
module tb_retire_stage;
   localparam int N = 3;
   localparam int ROB_SZ = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   retire_stage_if #(.N(N), .ROB_SZ(ROB_SZ), .CDB_W(N), .PREG_W(6), .REG_W(5)) bus ();

   retire_stage #(.N(N), .ROB_SZ(ROB_SZ), .CDB_W(N), .PREG_W(6), .REG_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.rob_outputs_t            = '0;
      bus.rob_outputs_t_old        = '0;
      bus.rob_outputs_dest_reg_idx = '0;
      bus.rob_outputs_has_dest     = '0;
      bus.rob_outputs_halt         = '0;
      bus.rob_outputs_valid        = '0;
      bus.rob_tail                 = '0;
      bus.tail_restore_valid       = 1'b0;
      bus.tail_restore             = '0;
      bus.cdb_valid                = '0;
      bus.cdb_rob_idx              = '0;
   endtask

   task automatic set_entry(input int lane, input logic [5:0] t, input logic [5:0] t_old,
                            input logic [4:0] dest, input logic has_dest, input logic halt);
      bus.rob_outputs_t[lane]            = t;
      bus.rob_outputs_t_old[lane]        = t_old;
      bus.rob_outputs_dest_reg_idx[lane] = dest;
      bus.rob_outputs_has_dest[lane]     = has_dest;
      bus.rob_outputs_halt[lane]         = halt;
   endtask

   task automatic set_cdb(input logic [2:0] v, input logic [2:0] i0, input logic [2:0] i1,
                          input logic [2:0] i2);
      bus.cdb_valid      = v;
      bus.cdb_rob_idx[0] = i0;
      bus.cdb_rob_idx[1] = i1;
      bus.cdb_rob_idx[2] = i2;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      cyc();
      cyc();
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd0) begin bad++; $display("FAIL reset_nr got=%0d exp=0", bus.num_retiring); end
      total++; if (bus.retired_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.retired_count); end
      total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", bus.halted); end
      total++; if (bus.free_valid !== 3'b000 || bus.arch_map_valid !== 3'b000) begin
         bad++; $display("FAIL reset_valids got=%b/%b exp=000/000", bus.free_valid, bus.arch_map_valid); end
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_no_complete();
      idle();
      bus.rob_outputs_valid = 2'd3;
      set_entry(0, 6'd1, 6'd2, 5'd1, 1'b1, 1'b0);
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd0) begin bad++; $display("FAIL nocomp_nr got=%0d exp=0", bus.num_retiring); end
      total++; if (bus.free_valid !== 3'b000) begin bad++; $display("FAIL nocomp_free got=%b exp=000", bus.free_valid); end
      cyc();
      total++; if (bus.retired_count !== 32'd0) begin bad++; $display("FAIL nocomp_count got=%0d exp=0", bus.retired_count); end
   endtask

   task automatic test_partial();
      idle();
      set_cdb(3'b011, 3'd0, 3'd1, 3'd0);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd3;
      set_entry(0, 6'd10, 6'd20, 5'd3, 1'b1, 1'b0);
      set_entry(1, 6'd11, 6'd21, 5'd4, 1'b0, 1'b0);
      set_entry(2, 6'd12, 6'd22, 5'd5, 1'b1, 1'b0);
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd2) begin bad++; $display("FAIL partial_nr got=%0d exp=2", bus.num_retiring); end
      total++; if (bus.free_valid !== 3'b001) begin bad++; $display("FAIL partial_free got=%b exp=001", bus.free_valid); end
      total++; if (bus.arch_map_valid !== 3'b001) begin bad++; $display("FAIL partial_map got=%b exp=001", bus.arch_map_valid); end
      total++; if (bus.free_preg[0] !== 6'd20) begin bad++; $display("FAIL partial_fpreg got=%0d exp=20", bus.free_preg[0]); end
      total++; if (bus.arch_map_reg[0] !== 5'd3 || bus.arch_map_preg[0] !== 6'd10) begin
         bad++; $display("FAIL partial_mapdata got=%0d/%0d exp=3/10", bus.arch_map_reg[0], bus.arch_map_preg[0]); end
      cyc();
      total++; if (bus.retired_count !== 32'd2) begin bad++; $display("FAIL partial_count got=%0d exp=2", bus.retired_count); end
      // head is now 2: only slot 2 completes, a single-entry offer retires it
      idle();
      set_cdb(3'b001, 3'd2, 3'd0, 3'd0);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd1;
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd1) begin bad++; $display("FAIL head2_nr got=%0d exp=1", bus.num_retiring); end
      cyc();
      total++; if (bus.retired_count !== 32'd3) begin bad++; $display("FAIL head2_count got=%0d exp=3", bus.retired_count); end
   endtask

   task automatic test_wrap();
      idle();
      set_cdb(3'b111, 3'd3, 3'd4, 3'd5);
      cyc();
      idle();
      set_cdb(3'b001, 3'd6, 3'd0, 3'd0);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd3;
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd3) begin bad++; $display("FAIL fill_nr got=%0d exp=3", bus.num_retiring); end
      cyc();
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd1) begin bad++; $display("FAIL head6_nr got=%0d exp=1", bus.num_retiring); end
      cyc();
      total++; if (bus.retired_count !== 32'd7) begin bad++; $display("FAIL head7_count got=%0d exp=7", bus.retired_count); end
      idle();
      set_cdb(3'b111, 3'd7, 3'd0, 3'd1);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd3;
      set_entry(0, 6'd11, 6'd21, 5'd1, 1'b1, 1'b0);
      set_entry(1, 6'd12, 6'd22, 5'd2, 1'b1, 1'b0);
      set_entry(2, 6'd13, 6'd23, 5'd3, 1'b1, 1'b0);
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd3) begin bad++; $display("FAIL wrap_nr got=%0d exp=3", bus.num_retiring); end
      total++; if (bus.free_valid !== 3'b111) begin bad++; $display("FAIL wrap_free got=%b exp=111", bus.free_valid); end
      total++; if (bus.free_preg[2] !== 6'd23 || bus.arch_map_reg[1] !== 5'd2) begin
         bad++; $display("FAIL wrap_lanes got=%0d/%0d exp=23/2", bus.free_preg[2], bus.arch_map_reg[1]); end
      cyc();
      total++; if (bus.retired_count !== 32'd10) begin bad++; $display("FAIL wrap_count got=%0d exp=10", bus.retired_count); end
   endtask

   task automatic test_squash();
      // head=2: complete 4,5,6, then squash [5,7) while lane 0 re-broadcasts slot 6
      idle();
      set_cdb(3'b111, 3'd4, 3'd5, 3'd6);
      cyc();
      idle();
      bus.tail_restore_valid = 1'b1;
      bus.tail_restore       = 3'd5;
      bus.rob_tail           = 3'd7;
      set_cdb(3'b001, 3'd6, 3'd0, 3'd0);
      cyc();
      idle();
      set_cdb(3'b011, 3'd2, 3'd3, 3'd0);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd3;
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd3) begin bad++; $display("FAIL squash_keep4 got=%0d exp=3", bus.num_retiring); end
      cyc();
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd0) begin bad++; $display("FAIL squash_clr5 got=%0d exp=0", bus.num_retiring); end
      cyc();
      total++; if (bus.retired_count !== 32'd13) begin bad++; $display("FAIL squash_count got=%0d exp=13", bus.retired_count); end
      // slot 6 must be clear too: complete 5 only, head=5, offer 2
      idle();
      set_cdb(3'b001, 3'd5, 3'd0, 3'd0);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd2;
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd1) begin bad++; $display("FAIL squash_clr6 got=%0d exp=1", bus.num_retiring); end
      cyc();
   endtask

   task automatic test_halt();
      // head=6, count=14
      idle();
      set_cdb(3'b111, 3'd6, 3'd7, 3'd0);
      cyc();
      idle();
      bus.rob_outputs_valid = 2'd3;
      set_entry(0, 6'd30, 6'd40, 5'd7, 1'b1, 1'b0);
      set_entry(1, 6'd31, 6'd41, 5'd8, 1'b0, 1'b1);
      set_entry(2, 6'd32, 6'd42, 5'd9, 1'b1, 1'b0);
      @(negedge clock);
      total++; if (bus.num_retiring !== 2'd2) begin bad++; $display("FAIL halt_nr got=%0d exp=2", bus.num_retiring); end
      total++; if (bus.free_valid !== 3'b001) begin bad++; $display("FAIL halt_free got=%b exp=001", bus.free_valid); end
      total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%0b exp=0", bus.halted); end
      cyc();
      @(negedge clock);
      total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%0b exp=1", bus.halted); end
      total++; if (bus.num_retiring !== 2'd0 || bus.arch_map_valid !== 3'b000) begin
         bad++; $display("FAIL halt_block got=%0d/%b exp=0/000", bus.num_retiring, bus.arch_map_valid); end
      cyc();
      total++; if (bus.retired_count !== 32'd16) begin bad++; $display("FAIL halt_count got=%0d exp=16", bus.retired_count); end
   endtask

   task automatic test_bypass();
      // reset mid-operation; the CDB set of slot 1 during reset must be dropped
      idle();
      reset = 1'b1;
      set_cdb(3'b001, 3'd1, 3'd0, 3'd0);
      cyc();
      idle();
      reset = 1'b0;
      total++; if (bus.retired_count !== 32'd0 || bus.halted !== 1'b0) begin
         bad++; $display("FAIL rst2_state got=%0d/%0b exp=0/0", bus.retired_count, bus.halted); end
      bus.rob_outputs_valid = 2'd2;
      set_cdb(3'b001, 3'd0, 3'd0, 3'd0);
      @(negedge clock);
`ifdef RETIRE_CDB_BYPASS_EN
      total++; if (bus.num_retiring !== 2'd1) begin bad++; $display("FAIL bypass_same got=%0d exp=1", bus.num_retiring); end
`else
      total++; if (bus.num_retiring !== 2'd0) begin bad++; $display("FAIL bypass_same got=%0d exp=0", bus.num_retiring); end
`endif
      cyc();
      bus.cdb_valid = '0;
      @(negedge clock);
`ifdef RETIRE_CDB_BYPASS_EN
      total++; if (bus.num_retiring !== 2'd0) begin bad++; $display("FAIL bypass_next got=%0d exp=0", bus.num_retiring); end
`else
      total++; if (bus.num_retiring !== 2'd1) begin bad++; $display("FAIL bypass_next got=%0d exp=1", bus.num_retiring); end
`endif
      cyc();
      total++; if (bus.retired_count !== 32'd1) begin bad++; $display("FAIL bypass_count got=%0d exp=1", bus.retired_count); end
   endtask

   initial begin
      idle();
      test_reset();
      test_no_complete();
      test_partial();
      test_wrap();
      test_squash();
      test_halt();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
